// File: rtl/opamp_sar_pkg.sv
// Shared types and defaults for the op-amp SAR conversion controller.
package opamp_sar_pkg;

    localparam int unsigned SAR_WIDTH  = 8;
    localparam int unsigned SAR_SETTLE = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } sar_state_e;

    // Settle counter only has to hold SETTLE_CYCLES-1
    function automatic int unsigned cnt_width(input int unsigned settle_cycles);
        return $clog2(settle_cycles);
    endfunction

endpackage

// File: rtl/opamp_sar_ctrl_cmp_sync.sv
// Two-flop synchronizer for the asynchronous comparator output.
module cmp_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/opamp_sar_ctrl.sv
// Successive-approximation controller driving an R-2R DAC and reading the
// op-amp comparator; one WIDTH-bit result per accepted start.
module opamp_sar_ctrl
    import opamp_sar_pkg::*;
#(
    parameter int unsigned WIDTH         = SAR_WIDTH,
    parameter int unsigned SETTLE_CYCLES = SAR_SETTLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CNT_W = cnt_width(SETTLE_CYCLES);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    sar_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] dac_d;
    logic [WIDTH-1:0] result_d;
    logic             cmp_s;

    cmp_sync u_cmp_sync (
        .clk (clk),
        .rst (rst),
        .d   (cmp_in),
        .q   (cmp_s)
    );

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        dac_d    = dac_code;
        result_d = result;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d            = IDX_W'(WIDTH - 1);
                    dac_d            = '0;
                    dac_d[WIDTH-1]   = 1'b1;
                    cnt_d            = CNT_W'(SETTLE_CYCLES - 1);
                    state_d          = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (!cmp_s) begin
                    dac_d[idx_q] = 1'b0;
                end
                if (idx_q != '0) begin
                    dac_d[idx_q - IDX_W'(1)] = 1'b1;
                    idx_d                    = idx_q - IDX_W'(1);
                    cnt_d                    = CNT_W'(SETTLE_CYCLES - 1);
                    state_d                  = SETTLE;
                end else begin
                    result_d = dac_d;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // busy and done are registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            dac_code <= '0;
            result   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            dac_code <= dac_d;
            result   <= result_d;
            busy     <= (state_d != IDLE);
            done     <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_opamp_sar_ctrl.sv
// Directed bench for opamp_sar_ctrl: default 8-bit instance plus a 4-bit,
// 3-cycle-settle instance, each against a behavioural comparator.
module tb_opamp_sar_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start4;
    logic       cmp8, cmp4;
    logic [7:0] dac8, res8;
    logic       busy8, done8;
    logic [3:0] dac4, res4;
    logic       busy4, done4;

    logic [1:0] mode;
    logic [7:0] vin8;
    logic [3:0] vin4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] trace[$];
    logic [7:0] ones_exp[8];
    logic [7:0] zeros_exp[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Vin modelled half an LSB above its code, so the SAR settles on vin itself
    assign cmp8 = (mode == 2'd0) ? (dac8 <= vin8) : (mode == 2'd1);
    assign cmp4 = (dac4 <= vin4);

    opamp_sar_ctrl u8 (
        .clk      (clk),
        .rst      (rst),
        .start    (start8),
        .cmp_in   (cmp8),
        .dac_code (dac8),
        .busy     (busy8),
        .done     (done8),
        .result   (res8)
    );

    opamp_sar_ctrl #(.WIDTH(4), .SETTLE_CYCLES(3)) u4 (
        .clk      (clk),
        .rst      (rst),
        .start    (start4),
        .cmp_in   (cmp4),
        .dac_code (dac4),
        .busy     (busy4),
        .done     (done4),
        .result   (res4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One conversion on u8: latency from acceptance to done, busy cycles, trial codes
    task automatic run8(output int lat, output int bcyc);
        logic [7:0] prev;
        trace.delete();
        prev   = dac8;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        bcyc   = busy8 ? 1 : 0;
        if (dac8 != prev) trace.push_back(dac8);
        prev = dac8;
        lat  = 0;
        while (!done8 && lat < 200) begin
            tick();
            lat++;
            if (busy8) bcyc++;
            if (dac8 != prev) begin
                trace.push_back(dac8);
                prev = dac8;
            end
        end
    endtask

    initial begin
        int lat, bcyc, n, nd, first, last;
        ones_exp  = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
        zeros_exp = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        rst    = 1'b1;
        start8 = 1'b0;
        start4 = 1'b0;
        mode   = 2'd0;
        vin8   = 8'hA5;
        vin4   = 4'h9;
        repeat (3) tick();
        chk("rst_dac8",  32'(dac8),  32'h0);
        chk("rst_res8",  32'(res8),  32'h0);
        chk("rst_busy8", 32'(busy8), 32'h0);
        chk("rst_done8", 32'(done8), 32'h0);
        chk("rst_dac4",  32'(dac4),  32'h0);
        chk("rst_res4",  32'(res4),  32'h0);
        rst = 1'b0;
        tick();

        // Vin = A5 against the comparator model
        run8(lat, bcyc);
        chk("a5_latency", 32'(lat), 32'd40);
        chk("a5_done",    32'(done8), 32'h1);
        chk("a5_result",  32'(res8), 32'hA5);
        chk("a5_busy_cycles", 32'(bcyc), 32'd41);
        tick();
        chk("a5_done_clear", 32'(done8), 32'h0);
        chk("a5_busy_clear", 32'(busy8), 32'h0);
        chk("a5_dac_hold",   32'(dac8), 32'hA5);
        chk("a5_result_hold", 32'(res8), 32'hA5);

        // Comparator stuck high: all ones, trials walk upward
        mode = 2'd1;
        run8(lat, bcyc);
        chk("ones_latency", 32'(lat), 32'd40);
        chk("ones_result",  32'(res8), 32'hFF);
        chk("ones_trials",  32'(trace.size()), 32'd8);
        for (int i = 0; i < 8 && i < trace.size(); i++)
            chk($sformatf("ones_trial%0d", i), 32'(trace[i]), 32'(ones_exp[i]));
        tick();

        // Comparator stuck low: zero, trials walk downward then clear
        mode = 2'd2;
        run8(lat, bcyc);
        chk("zeros_result", 32'(res8), 32'h00);
        chk("zeros_trials", 32'(trace.size()), 32'd9);
        for (int i = 0; i < 8 && i < trace.size(); i++)
            chk($sformatf("zeros_trial%0d", i), 32'(trace[i]), 32'(zeros_exp[i]));
        if (trace.size() > 8) chk("zeros_final", 32'(trace[8]), 32'h00);
        tick();

        // start held high: back-to-back conversions with one idle cycle
        mode   = 2'd0;
        vin8   = 8'h3C;
        start8 = 1'b1;
        last   = 0;
        for (int p = 0; p < 3; p++) begin
            n = 0;
            while (!done8 && n < 200) begin
                tick();
                n++;
            end
            chk($sformatf("b2b_done%0d", p), 32'(done8), 32'h1);
            chk($sformatf("b2b_result%0d", p), 32'(res8), 32'h3C);
            if (p > 0) chk($sformatf("b2b_period%0d", p), 32'(cyc - last), 32'd42);
            last = cyc;
            tick();
        end
        start8 = 1'b0;
        tick();
        chk("b2b_stop_busy", 32'(busy8), 32'h0);

        // Reset 20 cycles into a conversion
        vin8   = 8'hA5;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (19) tick();
        chk("abort_busy_before", 32'(busy8), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy",   32'(busy8), 32'h0);
        chk("abort_dac",    32'(dac8),  32'h0);
        chk("abort_result", 32'(res8),  32'h0);
        chk("abort_done",   32'(done8), 32'h0);
        nd = 0;
        repeat (60) begin
            tick();
            if (done8) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        chk("abort_idle_busy", 32'(busy8), 32'h0);

        // Second start pulse while busy is ignored
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n      = 0;
        nd     = 0;
        first  = -1;
        while (n < 60) begin
            tick();
            n++;
            if (n == 9)  start8 = 1'b1;
            if (n == 10) start8 = 1'b0;
            if (done8) begin
                nd++;
                if (first < 0) first = n;
            end
        end
        chk("ignore_first_done", 32'(first), 32'd40);
        chk("ignore_done_count", 32'(nd), 32'd1);
        chk("ignore_result",     32'(res8), 32'hA5);

        // Narrow instance: WIDTH=4, SETTLE_CYCLES=3
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("w4_busy", 32'(busy4), 32'h1);
        n = 0;
        while (!done4 && n < 100) begin
            tick();
            n++;
        end
        chk("w4_latency", 32'(n), 32'd16);
        chk("w4_result",  32'(res4), 32'h9);
        tick();
        chk("w4_busy_clear", 32'(busy4), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
